// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and constants for the BNN feature loader
// Purpose: loader state encoding, prediction width helper and the default
//          compute window of each sequential core product wrapper.
// Ports:   none (package)
package bnn_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // A single-class core would still need a one-bit prediction bus.
  function automatic int pred_w(input int class_cnt);
    return (class_cnt > 1) ? $clog2(class_cnt) : 1;
  endfunction

  // Cycles from core restart release to a valid prediction, per wrapper.
  localparam int ROMESH_SEQ_COMPUTE_CYCLES = 48;
  localparam int DEFAULT_COMPUTE_CYCLES    = ROMESH_SEQ_COMPUTE_CYCLES;

endpackage

// File: rtl/bnn_feat_shift.sv
// rtl/bnn_feat_shift.sv - indexed-write feature vector register
// Purpose: holds FEAT_CNT features of FEAT_BITS each; one slot written per
//          accepted beat, whole vector cleared by reset.
// Ports:   clk, rst (async, active-high clear), i_we (write strobe),
//          i_idx (slot), i_data (feature value), o_bus (packed vector,
//          slot i at [i*FEAT_BITS +: FEAT_BITS]).
module bnn_feat_shift #(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4,
  parameter int IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [IDX_W-1:0]              i_idx,
  input  logic [FEAT_BITS-1:0]          i_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] o_bus
);

  logic [FEAT_CNT*FEAT_BITS-1:0] r_bus;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus <= '0;
    end else if (i_we) begin
      for (int i = 0; i < FEAT_CNT; i++) begin
        if (i_idx == IDX_W'(i)) begin
          r_bus[i*FEAT_BITS +: FEAT_BITS] <= i_data;
        end
      end
    end
  end

  assign o_bus = r_bus;

endmodule

// File: rtl/bnn_feature_loader.sv
// rtl/bnn_feature_loader.sv - stream-to-parallel front end for sequential BNN cores
// Purpose: collects FEAT_CNT feature beats, restarts the core for one cycle,
//          waits COMPUTE_CYCLES, captures the prediction and offers it on a
//          valid/ready result stream. Optional macro LOADER_STATS_EN adds a
//          16-bit wrapping count of delivered results (infer_cnt).
// Ports:   clk, rst (async, active-high)
//          in_valid/in_ready/in_feat       feature beat stream, feature 0 first
//          features                        packed vector to the core
//          bnn_rst                         core restart (high in reset and KICK)
//          bnn_pred                        core prediction
//          out_valid/out_ready/out_pred    result stream
//          infer_cnt                       results delivered (LOADER_STATS_EN only)
module bnn_feature_loader
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT       = 11,
  parameter int FEAT_BITS      = 4,
  parameter int CLASS_CNT      = 6,
  parameter int COMPUTE_CYCLES = DEFAULT_COMPUTE_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FEAT_BITS-1:0]            in_feat,
  output logic [FEAT_CNT*FEAT_BITS-1:0]   features,
  output logic                            bnn_rst,
  input  logic [pred_w(CLASS_CNT)-1:0]    bnn_pred,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [pred_w(CLASS_CNT)-1:0]    out_pred
`ifdef LOADER_STATS_EN
  ,
  output logic [15:0]                     infer_cnt
`endif
);

  localparam int PW    = pred_w(CLASS_CNT);
  localparam int IDX_W = $clog2(FEAT_CNT + 1);
  localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_out_pred;
  logic             w_in_xfer;
  logic             w_last_beat;
  logic             w_cnt_done;
  logic             w_kick;

  assign w_in_xfer   = in_valid && in_ready;
  assign w_last_beat = (r_idx == IDX_W'(FEAT_CNT - 1));
  assign w_cnt_done  = (r_cnt == CNT_W'(COMPUTE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_kick       = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last_beat) begin
          w_next_state = KICK;
        end
      end
      KICK: begin
        w_kick       = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (w_cnt_done) begin
          w_next_state = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = LOAD;
        end
      end
      default: w_next_state = LOAD;
    endcase
  end

  // The core is held in restart for the whole of the loader reset as well.
  assign bnn_rst = rst | w_kick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_out_pred <= '0;
    end else begin
      if (w_in_xfer) begin
        r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
      end
      if (r_state == KICK) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == WAIT) && w_cnt_done) begin
        r_out_pred <= bnn_pred;
      end
    end
  end

  assign out_pred = r_out_pred;

  bnn_feat_shift #(
    .FEAT_CNT  (FEAT_CNT),
    .FEAT_BITS (FEAT_BITS),
    .IDX_W     (IDX_W)
  ) u_feat_shift (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_in_xfer),
    .i_idx  (r_idx),
    .i_data (in_feat),
    .o_bus  (features)
  );

`ifdef LOADER_STATS_EN
  logic [15:0] r_infer_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_infer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_infer_cnt <= r_infer_cnt + 16'd1;
    end
  end

  assign infer_cnt = r_infer_cnt;
`endif

endmodule

// File: tb/tb_bnn_feature_loader.sv
// tb/tb_bnn_feature_loader.sv - self-checking bench for bnn_feature_loader
module tb_bnn_feature_loader;

  localparam int FC   = 11;
  localparam int FB   = 4;
  localparam int CC   = 48;
  localparam int NCLS = 6;
  localparam int PW   = 3;
  localparam int BUSW = FC * FB;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [FB-1:0]   in_feat;
  logic [BUSW-1:0] features;
  logic            bnn_rst;
  logic [PW-1:0]   bnn_pred;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_pred;
`ifdef LOADER_STATS_EN
  logic [15:0]     infer_cnt;
`endif

  always #5 clk = ~clk;

  bnn_feature_loader #(
    .FEAT_CNT       (FC),
    .FEAT_BITS      (FB),
    .CLASS_CNT      (NCLS),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .features  (features),
    .bnn_rst   (bnn_rst),
    .bnn_pred  (bnn_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pred  (out_pred)
`ifdef LOADER_STATS_EN
    ,
    .infer_cnt (infer_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Golden core: weighted feature sum modulo class count. The prediction is
  // only correct exactly CC-1 cycles after restart release; any other cycle
  // shows a different class, so a mistimed capture is visible.
  function automatic logic [PW-1:0] core_fn(input logic [BUSW-1:0] v);
    int s;
    s = 0;
    for (int i = 0; i < FC; i++) s += (i + 1) * int'(v[i*FB +: FB]);
    return PW'(s % NCLS);
  endfunction

  int core_cnt = 0;
  always @(posedge clk) core_cnt <= bnn_rst ? 0 : core_cnt + 1;
  assign bnn_pred = (core_cnt == CC - 1) ? core_fn(features)
                                         : PW'((int'(core_fn(features)) + 1) % NCLS);

  logic [FB-1:0]   vec [FC];
  logic [BUSW-1:0] exp_bus;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_vec();
    for (int i = 0; i < FC; i++) exp_bus[i*FB +: FB] = vec[i];
  endtask

  task automatic rand_vec();
    for (int i = 0; i < FC; i++) vec[i] = FB'($urandom_range(0, 15));
    pack_vec();
  endtask

  // Sends the first nbeats of vec; returns at the negedge just after the
  // clock edge that accepted the last beat.
  task automatic send_vec(input bit gaps, input int nbeats);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_feat  = FB'($urandom);
        @(negedge clk);
      end
      n = 0;
      while (!in_ready && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_feat  = vec[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output int lat, output logic [PW-1:0] pred);
    lat = start;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    pred = out_pred;
  endtask

  int            lat;
  logic [PW-1:0] pred;
  int            held_bad;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bnn_rst", 64'(bnn_rst), 64'd1);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_pred", 64'(out_pred), 64'd0);
    check("reset_features", 64'(features), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_bnn_rst", 64'(bnn_rst), 64'd0);

    // 1: reset after 5 beats discards the partial vector
    rand_vec();
    send_vec(1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_features_clear", 64'(features), 64'd0);
    rand_vec();
    send_vec(1'b0, FC);
    check("t1_features", 64'(features), 64'(exp_bus));
    check("t1_first_beat", 64'(features[FB-1:0]), 64'(vec[0]));
    out_ready = 1'b1;
    wait_result(0, lat, pred);
    check("t1_latency", 64'(lat), 64'(1 + CC));
    check("t1_pred", 64'(pred), 64'(core_fn(exp_bus)));

    // 2: basic vector 1..B
    @(negedge clk);
    for (int i = 0; i < FC; i++) vec[i] = FB'(i + 1);
    pack_vec();
    send_vec(1'b0, FC);
    check("t2_features", 64'(features), 64'h0BA987654321);
    check("t2_kick_bnn_rst", 64'(bnn_rst), 64'd1);
    check("t2_kick_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t2_wait_bnn_rst", 64'(bnn_rst), 64'd0);
    wait_result(1, lat, pred);
    check("t2_latency", 64'(lat), 64'(1 + CC));
    check("t2_pred", 64'(pred), 64'(core_fn(exp_bus)));
    @(negedge clk);
    check("t2_out_valid_drop", 64'(out_valid), 64'd0);
    check("t2_in_ready_back", 64'(in_ready), 64'd1);

    // 3: gapped input
    rand_vec();
    send_vec(1'b1, FC);
    check("t3_features", 64'(features), 64'(exp_bus));
    check("t3_in_ready_drop", 64'(in_ready), 64'd0);
    wait_result(0, lat, pred);
    check("t3_latency", 64'(lat), 64'(1 + CC));
    check("t3_pred", 64'(pred), 64'(core_fn(exp_bus)));
    @(negedge clk);

    // 4: result back-pressure
    out_ready = 1'b0;
    rand_vec();
    send_vec(1'b0, FC);
    wait_result(0, lat, pred);
    check("t4_latency", 64'(lat), 64'(1 + CC));
    check("t4_pred", 64'(pred), 64'(core_fn(exp_bus)));
    held_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_pred !== core_fn(exp_bus) || in_ready !== 1'b0)
        held_bad++;
    end
    check("t4_held_cycles_bad", 64'(held_bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_out_valid_after", 64'(out_valid), 64'd0);
    check("t4_in_ready_after", 64'(in_ready), 64'd1);

    // 5: back-to-back vectors
    exp_q.delete();
    got_q.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          rand_vec();
          exp_q.push_back(core_fn(exp_bus));
          send_vec(1'b0, FC);
        end
      end
      begin
        for (int n = 0; n < 1000 && got_q.size() < 3; n++) begin
          @(negedge clk);
          if (out_valid && out_ready) got_q.push_back(out_pred);
        end
      end
    join
    check("t5_result_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      check($sformatf("t5_pred_%0d", k), 64'(got_q[k]), 64'(exp_q[k]));

`ifdef LOADER_STATS_EN
    // 6: inference counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_cnt_reset", 64'(infer_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      rand_vec();
      send_vec(1'b0, FC);
      wait_result(0, lat, pred);
      @(negedge clk);
    end
    check("t6_cnt_three", 64'(infer_cnt), 64'd3);
    force dut.r_infer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_infer_cnt;
    @(negedge clk);
    check("t6_cnt_preload", 64'(infer_cnt), 64'hFFFF);
    rand_vec();
    send_vec(1'b0, FC);
    wait_result(0, lat, pred);
    @(negedge clk);
    check("t6_cnt_wrap", 64'(infer_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
